// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave controller.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, RX_ADDR1, RX_ADDR2, ACK_ADDR, RX_DATA,
    ACK_DATA, NACK_DATA, TX_DATA, WAIT_MACK, WAIT_STOP
  } state_t;

  localparam logic [4:0] HDR10     = 5'b11110;
  localparam logic       DIR_WRITE = 1'b0;
  localparam logic       DIR_READ  = 1'b1;

endpackage

// File: rtl/i2c_byte_counter.sv
// Saturating data-byte counter with synchronous clear.
module i2c_byte_counter #(
  parameter int CNT_W     = 5,
  parameter int MAX_BYTES = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  assign full = (count == MAX_CNT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)             count <= '0;
    else if (clr)         count <= '0;
    else if (inc && !full) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave transfer sequencer: address match (7/10-bit), write data ACK/NACK, read data hand-off.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter int ADDR_MODE = 7,
  parameter int MAX_BYTES = 16,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start_Condition,
  input  logic             Stop_Condition,
  input  logic [9:0]       Slave_Address,
  input  logic             done_receiving,
  input  logic [7:0]       received_byte,
  input  logic             done_ack,
  input  logic             done_sending,
  input  logic             master_ack,
  input  logic [7:0]       data_in,
  input  logic             data_in_vld,
  output logic             byte_receiver_enable,
  output logic             byte_sender_enable,
  output logic             ACK_Gen_enable,
  output logic             ACK_OUT,
  output logic             N_ACK_OUT,
  output logic [7:0]       tx_byte,
  output logic [7:0]       data_out,
  output logic             data_vld,
  output logic             data_req,
  output logic             r_w,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count
);

  state_t state, state_nxt;
  logic   held, hdr_ack, addr10_ok, full, no_bus_ev;

  assign no_bus_ev = !Stop_Condition && !Start_Condition;
  assign busy      = (state != IDLE);

  i2c_byte_counter #(.CNT_W(CNT_W), .MAX_BYTES(MAX_BYTES)) u_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (Start_Condition && !Stop_Condition),
    .inc   ((state == ACK_DATA && state_nxt == RX_DATA) ||
            (state == TX_DATA  && state_nxt == WAIT_MACK)),
    .count (byte_count),
    .full  (full)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    byte_receiver_enable = 1'b0;
    byte_sender_enable   = 1'b0;
    ACK_Gen_enable       = 1'b0;
    ACK_OUT              = 1'b0;
    N_ACK_OUT            = 1'b0;
    if (Stop_Condition)       state_nxt = IDLE;
    else if (Start_Condition) state_nxt = RX_ADDR1;
    else begin
      case (state)
        RX_ADDR1: if (done_receiving) begin
          if (ADDR_MODE == 10) begin
            if (received_byte[7:1] != {HDR10, Slave_Address[9:8]}) state_nxt = WAIT_STOP;
            else if (received_byte[0] == DIR_WRITE)                state_nxt = RX_ADDR2;
            else state_nxt = addr10_ok ? ACK_ADDR : WAIT_STOP;
          end else begin
            state_nxt = (received_byte[7:1] == Slave_Address[6:0]) ? ACK_ADDR : WAIT_STOP;
          end
        end
        RX_ADDR2: if (done_receiving && !hdr_ack)
          state_nxt = (received_byte == Slave_Address[7:0]) ? ACK_ADDR : WAIT_STOP;
        ACK_ADDR:  if (done_ack) state_nxt = (r_w == DIR_READ) ? TX_DATA : RX_DATA;
        RX_DATA:   if (done_receiving) state_nxt = full ? NACK_DATA : ACK_DATA;
        ACK_DATA:  if (done_ack) state_nxt = RX_DATA;
        NACK_DATA: if (done_ack) state_nxt = WAIT_STOP;
        TX_DATA:   if (done_sending && held) state_nxt = WAIT_MACK;
        WAIT_MACK: state_nxt = master_ack ? TX_DATA : WAIT_STOP;
        default:   state_nxt = state;
      endcase
    end
    // The first 10-bit header byte is ACKed from inside RX_ADDR2 before the low address byte is received.
    case (state)
      RX_ADDR1, RX_DATA: byte_receiver_enable = 1'b1;
      RX_ADDR2: if (hdr_ack) begin
        ACK_Gen_enable = 1'b1;
        ACK_OUT        = 1'b1;
      end else byte_receiver_enable = 1'b1;
      ACK_ADDR, ACK_DATA: begin
        ACK_Gen_enable = 1'b1;
        ACK_OUT        = 1'b1;
      end
      NACK_DATA: begin
        ACK_Gen_enable = 1'b1;
        N_ACK_OUT      = 1'b1;
      end
      TX_DATA: byte_sender_enable = held;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_w       <= 1'b0;
      addr10_ok <= 1'b0;
      data_out  <= '0;
      tx_byte   <= '0;
      data_vld  <= 1'b0;
      data_req  <= 1'b0;
      held      <= 1'b0;
      hdr_ack   <= 1'b0;
    end else begin
      data_vld <= 1'b0;
      data_req <= (state_nxt == TX_DATA) && (state == ACK_ADDR || state == WAIT_MACK);
      if (state == RX_ADDR1 && done_receiving && no_bus_ev) r_w <= received_byte[0];
      if (Stop_Condition) addr10_ok <= 1'b0;
      else if (state == RX_ADDR2 && state_nxt == ACK_ADDR) addr10_ok <= 1'b1;
      if (state_nxt != RX_ADDR2)  hdr_ack <= 1'b0;
      else if (state != RX_ADDR2) hdr_ack <= 1'b1;
      else if (done_ack)          hdr_ack <= 1'b0;
      if (state == RX_DATA && state_nxt == ACK_DATA) begin
        data_out <= received_byte;
        data_vld <= 1'b1;
      end
      if (state_nxt != TX_DATA) held <= 1'b0;
      else if (state == TX_DATA && !held && data_in_vld) begin
        held    <= 1'b1;
        tx_byte <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: vector table, 7/10-bit hand sequences, reset abort, random transfers vs a transfer-level model.
module tb_i2c_slave_ctrl;

  localparam int MAXA = 2;

  logic CLK = 1'b0, RST = 1'b0;
  logic start, stop, drx, dack, dsnd, mack, dinv;
  logic [9:0] saddr;
  logic [7:0] rbyte, din;

  logic a_rxe, a_sne, a_ackg, a_acko, a_nack, a_dvld, a_dreq, a_rw, a_busy;
  logic [7:0] a_tx, a_dout;
  logic [1:0] a_cnt;
  logic b_rxe, b_sne, b_ackg, b_acko, b_nack, b_dvld, b_dreq, b_rw, b_busy;
  logic [7:0] b_tx, b_dout;
  logic [4:0] b_cnt;

  always #5 CLK = ~CLK;

  i2c_slave_ctrl #(.ADDR_MODE(7), .MAX_BYTES(MAXA)) u7 (
    .CLK(CLK), .RST(RST), .Start_Condition(start), .Stop_Condition(stop),
    .Slave_Address(saddr), .done_receiving(drx), .received_byte(rbyte),
    .done_ack(dack), .done_sending(dsnd), .master_ack(mack),
    .data_in(din), .data_in_vld(dinv),
    .byte_receiver_enable(a_rxe), .byte_sender_enable(a_sne), .ACK_Gen_enable(a_ackg),
    .ACK_OUT(a_acko), .N_ACK_OUT(a_nack), .tx_byte(a_tx), .data_out(a_dout),
    .data_vld(a_dvld), .data_req(a_dreq), .r_w(a_rw), .busy(a_busy), .byte_count(a_cnt));

  i2c_slave_ctrl #(.ADDR_MODE(10)) u10 (
    .CLK(CLK), .RST(RST), .Start_Condition(start), .Stop_Condition(stop),
    .Slave_Address(saddr), .done_receiving(drx), .received_byte(rbyte),
    .done_ack(dack), .done_sending(dsnd), .master_ack(mack),
    .data_in(din), .data_in_vld(dinv),
    .byte_receiver_enable(b_rxe), .byte_sender_enable(b_sne), .ACK_Gen_enable(b_ackg),
    .ACK_OUT(b_acko), .N_ACK_OUT(b_nack), .tx_byte(b_tx), .data_out(b_dout),
    .data_vld(b_dvld), .data_req(b_dreq), .r_w(b_rw), .busy(b_busy), .byte_count(b_cnt));

  // Control view {busy, rx_en, ack_gen, ack_out, nack_out, tx_en}
  wire [5:0] a_ctl = {a_busy, a_rxe, a_ackg, a_acko, a_nack, a_sne};
  wire [5:0] b_ctl = {b_busy, b_rxe, b_ackg, b_acko, b_nack, b_sne};
  localparam logic [5:0] C_IDLE = 6'b000000, C_RX = 6'b110000, C_ACK = 6'b101100,
                         C_NACK = 6'b101010, C_WS = 6'b100000, C_TX = 6'b100001;

  int passed = 0, total = 0, vld_cnt = 0;
  logic [7:0] got_q[$];

  always @(posedge CLK) if (a_dvld) begin
    got_q.push_back(a_dout);
    vld_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic clr_in();
    start = 1'b0; stop = 1'b0; drx = 1'b0; dack = 1'b0; dsnd = 1'b0; dinv = 1'b0;
  endtask

  task automatic do_start(); start = 1'b1; step(); start = 1'b0; endtask
  task automatic do_stop();  stop  = 1'b1; step(); stop  = 1'b0; endtask
  task automatic do_ack();   dack  = 1'b1; step(); dack  = 1'b0; endtask
  task automatic rx(input logic [7:0] b); rbyte = b; drx = 1'b1; step(); drx = 1'b0; endtask

  typedef struct {
    string nm;
    logic st, sp, rx, ak;
    logic [7:0] b;
    logic [9:0] ad;
    logic [5:0] ctl;
    logic dv;
    logic [7:0] dout;
    int cnt;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(string nm, logic st, logic sp, logic r, logic ak, logic [7:0] b,
                              logic [9:0] ad, logic [5:0] ctl, logic dv, logic [7:0] dout, int cnt);
    vec_t x;
    x.nm = nm; x.st = st; x.sp = sp; x.rx = r; x.ak = ak; x.b = b; x.ad = ad;
    x.ctl = ctl; x.dv = dv; x.dout = dout; x.cnt = cnt;
    return x;
  endfunction

  // Master-side read of k bytes; master ACKs all but the last. Data is 0x11,0x22,.. or random.
  task automatic do_read(input logic [6:0] a, input int k, input bit rnd);
    logic [7:0] d;
    saddr = {3'b000, a};
    do_stop(); do_start();
    rx({a, 1'b1});
    chk("rd addr ack", int'(a_ctl), int'(C_ACK));
    chk("rd r_w", int'(a_rw), 1);
    do_ack();
    for (int i = 0; i < k; i++) begin
      chk("rd data_req", int'(a_dreq), 1);
      for (int s = 0; s < (rnd ? int'($urandom_range(0, 3)) : 1); s++) step();
      chk("rd stall tx_en", int'(a_ctl), int'(C_WS));
      d = rnd ? 8'($urandom) : 8'(8'h11 * (i + 1));
      din = d; dinv = 1'b1; step(); dinv = 1'b0;
      chk("rd tx_en", int'(a_ctl), int'(C_TX));
      chk("rd tx_byte", int'(a_tx), int'(d));
      mack = (i < k - 1); dsnd = 1'b1; step(); dsnd = 1'b0;
      chk("rd count", int'(a_cnt), (i + 1 < MAXA) ? i + 1 : MAXA);
      step();
    end
    chk("rd end wait_stop", int'(a_ctl), int'(C_WS));
    chk("rd end data_req", int'(a_dreq), 0);
    mack = 1'b0;
    do_stop();
  endtask

  // Master-side write: address (matching or one bit off), then n data bytes until NACKed.
  task automatic rnd_write();
    int n = $urandom_range(0, 4);
    bit match = ($urandom_range(0, 3) != 0);
    logic [6:0] a = 7'($urandom);
    logic [6:0] sent = match ? a : a ^ (7'd1 << $urandom_range(0, 6));
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int acked = 0;
    saddr = {3'b000, a};
    do_stop();
    got_q.delete();
    do_start();
    rx({sent, 1'b0});
    chk("wr addr", int'(a_ctl), int'(match ? C_ACK : C_WS));
    if (match) begin
      do_ack();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        rx(b);
        chk("wr byte ack", int'(a_ctl), int'((i < MAXA) ? C_ACK : C_NACK));
        do_ack();
        if (i >= MAXA) break;
        exp_q.push_back(b);
        acked++;
      end
    end
    do_stop();
    chk("wr count", int'(a_cnt), acked);
    chk("wr vld pulses", got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) chk("wr data", int'(got_q[i]), int'(exp_q[i]));
  endtask

  initial begin
    int base;
    clr_in(); mack = 1'b0; din = 8'h00; rbyte = 8'h00; saddr = 10'h02A;
    step(); step();
    chk("rst ctl7", int'(a_ctl), 0);
    chk("rst ctl10", int'(b_ctl), 0);
    chk("rst cnt", int'(a_cnt), 0);
    chk("rst regs", int'({a_dvld, a_dreq, a_rw, a_tx, a_dout}), 0);
    RST = 1'b1;

    // 7-bit write with overflow at MAX_BYTES=2, then address mismatch and stop priority
    v.push_back(mk("v0 stop",     1'b0,1'b1,1'b0,1'b0, 8'h00, 10'h02A, C_IDLE, 1'b0, 8'h00, 0));
    v.push_back(mk("v1 start",    1'b1,1'b0,1'b0,1'b0, 8'h00, 10'h02A, C_RX,   1'b0, 8'h00, 0));
    v.push_back(mk("v2 addr",     1'b0,1'b0,1'b1,1'b0, 8'h54, 10'h02A, C_ACK,  1'b0, 8'h00, 0));
    v.push_back(mk("v3 ack",      1'b0,1'b0,1'b0,1'b1, 8'h00, 10'h02A, C_RX,   1'b0, 8'h00, 0));
    v.push_back(mk("v4 a5",       1'b0,1'b0,1'b1,1'b0, 8'hA5, 10'h02A, C_ACK,  1'b1, 8'hA5, 0));
    v.push_back(mk("v5 hold",     1'b0,1'b0,1'b0,1'b0, 8'h00, 10'h02A, C_ACK,  1'b0, 8'h00, 0));
    v.push_back(mk("v6 ack",      1'b0,1'b0,1'b0,1'b1, 8'h00, 10'h02A, C_RX,   1'b0, 8'h00, 1));
    v.push_back(mk("v7 3c",       1'b0,1'b0,1'b1,1'b0, 8'h3C, 10'h02A, C_ACK,  1'b1, 8'h3C, 1));
    v.push_back(mk("v8 ack",      1'b0,1'b0,1'b0,1'b1, 8'h00, 10'h02A, C_RX,   1'b0, 8'h00, 2));
    v.push_back(mk("v9 ovf",      1'b0,1'b0,1'b1,1'b0, 8'h77, 10'h02A, C_NACK, 1'b0, 8'h00, 2));
    v.push_back(mk("v10 nack",    1'b0,1'b0,1'b0,1'b1, 8'h00, 10'h02A, C_WS,   1'b0, 8'h00, 2));
    v.push_back(mk("v11 ws rx",   1'b0,1'b0,1'b1,1'b0, 8'h11, 10'h02A, C_WS,   1'b0, 8'h00, 2));
    v.push_back(mk("v12 stop",    1'b0,1'b1,1'b0,1'b0, 8'h00, 10'h02A, C_IDLE, 1'b0, 8'h00, 2));
    v.push_back(mk("v13 start",   1'b1,1'b0,1'b0,1'b0, 8'h00, 10'h02B, C_RX,   1'b0, 8'h00, 0));
    v.push_back(mk("v14 mism",    1'b0,1'b0,1'b1,1'b0, 8'h54, 10'h02B, C_WS,   1'b0, 8'h00, 0));
    v.push_back(mk("v15 ws ack",  1'b0,1'b0,1'b0,1'b1, 8'h00, 10'h02B, C_WS,   1'b0, 8'h00, 0));
    v.push_back(mk("v16 stop",    1'b0,1'b1,1'b0,1'b0, 8'h00, 10'h02B, C_IDLE, 1'b0, 8'h00, 0));
    v.push_back(mk("v17 start",   1'b1,1'b0,1'b0,1'b0, 8'h00, 10'h02A, C_RX,   1'b0, 8'h00, 0));
    v.push_back(mk("v18 st+sp",   1'b1,1'b1,1'b0,1'b0, 8'h00, 10'h02A, C_IDLE, 1'b0, 8'h00, 0));
    v.push_back(mk("v19 idle",    1'b0,1'b0,1'b0,1'b0, 8'h00, 10'h02A, C_IDLE, 1'b0, 8'h00, 0));
    base = vld_cnt;
    foreach (v[i]) begin
      start = v[i].st; stop = v[i].sp; drx = v[i].rx; dack = v[i].ak;
      rbyte = v[i].b; saddr = v[i].ad;
      step();
      chk({v[i].nm, " ctl"}, int'(a_ctl), int'(v[i].ctl));
      chk({v[i].nm, " dvld"}, int'(a_dvld), int'(v[i].dv));
      if (v[i].dv) chk({v[i].nm, " dout"}, int'(a_dout), int'(v[i].dout));
      chk({v[i].nm, " cnt"}, int'(a_cnt), v[i].cnt);
    end
    clr_in();
    chk("table vld pulses", vld_cnt - base, 2);

    // 7-bit read: ACK then NACK
    do_read(7'h2A, 2, 1'b0);

    // 10-bit: write header, low byte, repeated start, read header
    saddr = 10'h2C5;
    do_stop(); do_start();
    chk("10b rx_addr1", int'(b_ctl), int'(C_RX));
    rx(8'hF4);
    chk("10b hdr ack", int'(b_ctl), int'(C_ACK));
    do_ack();
    chk("10b rx_addr2", int'(b_ctl), int'(C_RX));
    rx(8'hC5);
    chk("10b low ack", int'(b_ctl), int'(C_ACK));
    chk("10b r_w wr", int'(b_rw), 0);
    do_ack();
    do_start();
    chk("10b rstart cnt", int'(b_cnt), 0);
    rx(8'hF5);
    chk("10b rd hdr ack", int'(b_ctl), int'(C_ACK));
    chk("10b r_w rd", int'(b_rw), 1);
    do_ack();
    chk("10b tx_data", int'(b_ctl), int'(C_WS));
    chk("10b data_req", int'(b_dreq), 1);
    do_stop(); do_start();
    rx(8'hF5);
    chk("10b rd w/o addr", int'(b_ctl), int'(C_WS));
    do_stop(); do_start();
    rx(8'hF4); do_ack(); rx(8'hC4);
    chk("10b low mism", int'(b_ctl), int'(C_WS));
    do_stop(); do_start();
    rx(8'hF6);
    chk("10b hdr mism", int'(b_ctl), int'(C_WS));
    do_stop();

    // Reset asserted while receiving data
    saddr = 10'h02A;
    do_start(); rx(8'h54); do_ack();
    chk("mid rx_data", int'(a_ctl), int'(C_RX));
    base = vld_cnt;
    rbyte = 8'h99; drx = 1'b1;
    #2 RST = 1'b0;
    #1;
    chk("mid rst ctl", int'(a_ctl), 0);
    chk("mid rst regs", int'({a_dvld, a_dreq, a_rw, a_cnt, a_tx, a_dout}), 0);
    step(); drx = 1'b0;
    step();
    RST = 1'b1;
    step();
    chk("mid rst idle", int'(a_ctl), int'(C_IDLE));
    chk("mid rst no vld", vld_cnt - base, 0);

    for (int t = 0; t < 24; t++) begin
      if (t % 3 == 2) do_read(7'($urandom), int'($urandom_range(1, 4)), 1'b1);
      else            rnd_write();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
